// File: rtl/muxn_if.sv
// Handshake bundle for muxn: per-channel inputs, control token channel and the buffered output.
interface muxn_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4,
  parameter int unsigned LW = 4
);
  localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]   r_i;
  logic [CH-1:0]   a_i;
  logic [CH*N-1:0] d_i;
  logic            ctl_r;
  logic            ctl_a;
  logic [SW-1:0]   ctl_sel;
  logic [LW-1:0]   ctl_len;
  logic            r_o;
  logic            a_o;
  logic [N-1:0]    d_o;
  logic            err;

  // Environment side: producers, token source and consumer.
  modport master (
    output r_i, d_i, ctl_r, ctl_sel, ctl_len, a_o,
    input  a_i, ctl_a, r_o, d_o, err
  );

  // Multiplexer side.
  modport slave (
    input  r_i, d_i, ctl_r, ctl_sel, ctl_len, a_o,
    output a_i, ctl_a, r_o, d_o, err
  );
endinterface

// File: rtl/muxn.sv
// N-channel burst multiplexer: a control token picks a channel and burst length,
// the selected items are merged in token order through a registered 2-entry output FIFO.
module muxn #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4,
  parameter int unsigned LW = 4
) (
  input  logic   clk,
  input  logic   rst,
  muxn_if.slave  bus
);
  localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [N-1:0]  head_q, head_d;
  logic [N-1:0]  tail_q, tail_d;
  logic          ctl_a_q, ctl_a_d;
  logic          err_q, err_d;
  logic          r_o_q, r_o_d;
  logic [CH-1:0] a_i_q, a_i_d;

  logic [N-1:0]  ch_data [CH];
  logic [N-1:0]  push_data;
  logic          ctl_xfer;
  logic          push;
  logic          pop;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign ch_data[k] = bus.d_i[k*N +: N];
  end

  // a_i_q is only ever nonzero on the selected channel during a burst.
  assign ctl_xfer  = bus.ctl_r && ctl_a_q;
  assign push      = |(bus.r_i & a_i_q);
  assign pop       = r_o_q && bus.a_o;
  assign push_data = ch_data[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;

    case (state_q)
      IDLE: begin
        if (ctl_xfer) begin
          if (32'(bus.ctl_sel) >= CH) begin
            err_d = 1'b1;
          end else begin
            sel_d   = bus.ctl_sel;
            rem_d   = bus.ctl_len;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (push) begin
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Head register doubles as d_o; tail holds the second entry.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase

    ctl_a_d = (state_d == IDLE);
    r_o_d   = (cnt_d != 2'd0);
    a_i_d   = '0;
    for (int k = 0; k < CH; k++) begin
      a_i_d[k] = (state_d == BURST) && (sel_d == SW'(k)) && (cnt_d != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ctl_a_q <= 1'b0;
      err_q   <= 1'b0;
      r_o_q   <= 1'b0;
      a_i_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ctl_a_q <= ctl_a_d;
      err_q   <= err_d;
      r_o_q   <= r_o_d;
      a_i_q   <= a_i_d;
    end
  end

  assign bus.a_i   = a_i_q;
  assign bus.ctl_a = ctl_a_q;
  assign bus.r_o   = r_o_q;
  assign bus.d_o   = head_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_muxn.sv
// Bench for muxn: directed scenarios plus randomized traffic against a token-order scoreboard.
module tb_muxn;
  localparam int unsigned N  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] len;
  } tok_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muxn_if #(.N(N), .CH(CH), .LW(LW)) bus  ();
  muxn_if #(.N(N), .CH(3),  .LW(LW)) bus3 ();

  muxn #(.N(N), .CH(CH), .LW(LW)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  muxn #(.N(N), .CH(3),  .LW(LW)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [N-1:0] src [CH][$];
  tok_t         ctlq[$];
  logic [N-1:0] outq[$];
  logic [N-1:0] popped[$];
  int           pop_cyc[$];
  int           xcyc [CH][$];
  int           n_xfer [CH];

  logic [CH-1:0] xfer;
  logic          ctl_x;
  logic          m_idle;
  int            m_sel;
  int            m_left;
  logic          exp_ctl_a;
  logic          exp_err;
  logic          rnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    outq.delete();
    m_idle    = 1'b1;
    m_sel     = 0;
    m_left    = 0;
    exp_ctl_a = 1'b0;
    exp_err   = 1'b0;
    xfer      = '0;
    ctl_x     = 1'b0;
  endtask

  // Sample at the falling edge, compare, then advance the reference past the rising edge.
  task automatic tick();
    logic [CH-1:0] exp_ai;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check("rst_r_o",   32'(bus.r_o),   32'd0);
      check("rst_a_i",   32'(bus.a_i),   32'd0);
      check("rst_d_o",   32'(bus.d_o),   32'd0);
      check("rst_ctl_a", 32'(bus.ctl_a), 32'd0);
      check("rst_err",   32'(bus.err),   32'd0);
      model_reset();
    end else begin
      exp_ai = '0;
      if (!m_idle && outq.size() < 2) exp_ai[m_sel] = 1'b1;
      check("ctl_a", 32'(bus.ctl_a), 32'(exp_ctl_a));
      check("err",   32'(bus.err),   32'(exp_err));
      check("a_i",   32'(bus.a_i),   32'(exp_ai));
      check("r_o",   32'(bus.r_o),   32'(outq.size() != 0));
      if (outq.size() != 0) check("d_o", 32'(bus.d_o), 32'(outq[0]));

      xfer  = bus.r_i & bus.a_i;
      ctl_x = bus.ctl_r && bus.ctl_a;
      if (bus.r_o && bus.a_o && outq.size() != 0) begin
        outq.delete(0);
        popped.push_back(bus.d_o);
        pop_cyc.push_back(cyc);
      end
      exp_err = 1'b0;
      if (!m_idle && xfer[m_sel]) begin
        outq.push_back(bus.d_i[m_sel*N +: N]);
        m_left--;
        if (m_left == 0) m_idle = 1'b1;
      end else if (m_idle && ctl_x) begin
        if (int'(bus.ctl_sel) >= int'(CH)) exp_err = 1'b1;
        else begin
          m_idle = 1'b0;
          m_sel  = int'(bus.ctl_sel);
          m_left = int'(bus.ctl_len) + 1;
        end
      end
      for (int k = 0; k < int'(CH); k++) begin
        if (xfer[k]) begin
          n_xfer[k]++;
          xcyc[k].push_back(cyc);
        end
      end
      exp_ctl_a = m_idle;
    end
    @(posedge clk);
    #1;
  endtask

  // Producers and token source: hold request and data until the transfer.
  task automatic drive();
    for (int k = 0; k < int'(CH); k++) begin
      if (xfer[k] && src[k].size() != 0) src[k].delete(0);
      if (!(bus.r_i[k] && !xfer[k] && src[k].size() != 0))
        bus.r_i[k] = (src[k].size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      bus.d_i[k*N +: N] = bus.r_i[k] ? src[k][0] : N'($urandom);
    end
    if (ctl_x && ctlq.size() != 0) ctlq.delete(0);
    if (!(bus.ctl_r && !ctl_x && ctlq.size() != 0))
      bus.ctl_r = (ctlq.size() != 0) && (!rnd || $urandom_range(0, 2) != 0);
    if (bus.ctl_r) begin
      bus.ctl_sel = ctlq[0].sel;
      bus.ctl_len = ctlq[0].len;
    end else begin
      bus.ctl_sel = 2'($urandom);
      bus.ctl_len = 4'($urandom);
    end
    xfer  = '0;
    ctl_x = 1'b0;
  endtask

  task automatic step();
    tick();
    drive();
  endtask

  task automatic run_until_pops(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while (popped.size() < n && b > 0) begin
      step();
      b--;
    end
    check(tag, 32'(popped.size()), 32'(n));
  endtask

  task automatic clear_logs();
    popped.delete();
    pop_cyc.delete();
    for (int k = 0; k < int'(CH); k++) xcyc[k].delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0] sb_exp [4];
    logic [N-1:0] bp_items [6];
    logic [N-1:0] b2b_exp [3];
    logic [N-1:0] mid_items [8];
    tok_t t;
    int   base, budget, total, aop, got, c;

    sb_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < int'(CH); k++) n_xfer[k] = 0;
    rnd        = 1'b0;
    bus.r_i    = '0;
    bus.d_i    = '0;
    bus.ctl_r  = 1'b0;
    bus.ctl_sel = '0;
    bus.ctl_len = '0;
    bus.a_o    = 1'b0;
    bus3.r_i   = '0;
    bus3.d_i   = '0;
    bus3.ctl_r = 1'b0;
    bus3.ctl_sel = '0;
    bus3.ctl_len = '0;
    bus3.a_o   = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.r_i     = 4'($urandom);
      bus.d_i     = 32'($urandom);
      bus.ctl_r   = 1'($urandom);
      bus.ctl_sel = 2'($urandom);
      bus.ctl_len = 4'($urandom);
      bus.a_o     = 1'($urandom);
    end
    bus.r_i   = '0;
    bus.ctl_r = 1'b0;
    bus.a_o   = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("ctl_a_after_reset", 32'(bus.ctl_a), 32'd1);

    // Single burst from channel 2.
    clear_logs();
    bus.a_o = 1'b1;
    ctlq.push_back('{sel: 2'd2, len: 4'd3});
    for (int i = 0; i < 4; i++) src[2].push_back(sb_exp[i]);
    drive();
    run_until_pops(4, 20, "sb_count");
    for (int i = 0; i < 4 && i < popped.size(); i++) check("sb_data", 32'(popped[i]), 32'(sb_exp[i]));
    if (pop_cyc.size() == 4) check("sb_consecutive", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    step();
    check("sb_ctl_a_back", 32'(bus.ctl_a), 32'd1);

    // Backpressure on channel 1.
    clear_logs();
    bus.a_o = 1'b0;
    base = n_xfer[1];
    for (int i = 0; i < 6; i++) begin
      bp_items[i] = N'($urandom);
      src[1].push_back(bp_items[i]);
    end
    ctlq.push_back('{sel: 2'd1, len: 4'd5});
    drive();
    for (int i = 0; i < 10; i++) step();
    check("bp_accepted", 32'(n_xfer[1] - base), 32'd2);
    check("bp_a_i_low", 32'(bus.a_i[1]), 32'd0);
    bus.a_o = 1'b1;
    run_until_pops(6, 30, "bp_count");
    for (int i = 0; i < 6 && i < popped.size(); i++) check("bp_data", 32'(popped[i]), 32'(bp_items[i]));

    // Back-to-back tokens: ch0 single item, then two from ch3.
    clear_logs();
    b2b_exp = '{8'hC0, 8'hD0, 8'hD1};
    src[0].push_back(b2b_exp[0]);
    src[3].push_back(b2b_exp[1]);
    src[3].push_back(b2b_exp[2]);
    ctlq.push_back('{sel: 2'd0, len: 4'd0});
    ctlq.push_back('{sel: 2'd3, len: 4'd1});
    drive();
    run_until_pops(3, 20, "b2b_count");
    for (int i = 0; i < 3 && i < popped.size(); i++) check("b2b_data", 32'(popped[i]), 32'(b2b_exp[i]));
    if (xcyc[0].size() != 0 && xcyc[3].size() != 0)
      check("b2b_gap", 32'(xcyc[3][0] - xcyc[0][0]), 32'd2);
    else
      check("b2b_xfers_seen", 32'(xcyc[3].size()), 32'd2);

    // Reset in the middle of an 8-item burst with the buffer full.
    clear_logs();
    bus.a_o = 1'b0;
    base = n_xfer[2];
    for (int i = 0; i < 8; i++) begin
      mid_items[i] = N'($urandom);
      src[2].push_back(mid_items[i]);
    end
    ctlq.push_back('{sel: 2'd2, len: 4'd7});
    drive();
    budget = 10;
    while (n_xfer[2] - base < 2 && budget > 0) begin
      step();
      budget--;
    end
    step();
    check("mid_accepted", 32'(n_xfer[2] - base), 32'd2);
    check("mid_r_o_full", 32'(bus.r_o), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_r_o",   32'(bus.r_o),   32'd0);
    check("mid_rst_a_i",   32'(bus.a_i),   32'd0);
    check("mid_rst_d_o",   32'(bus.d_o),   32'd0);
    check("mid_rst_ctl_a", 32'(bus.ctl_a), 32'd0);
    for (int k = 0; k < int'(CH); k++) src[k].delete();
    ctlq.delete();
    step();
    step();
    rst = 1'b1;
    step();
    step();
    clear_logs();
    bus.a_o = 1'b1;
    src[1].push_back(8'h99);
    ctlq.push_back('{sel: 2'd1, len: 4'd0});
    drive();
    run_until_pops(1, 15, "mid_new_count");
    for (int i = 0; i < 5; i++) step();
    check("mid_only_new", 32'(popped.size()), 32'd1);
    if (popped.size() != 0) check("mid_new_data", 32'(popped[0]), 32'h99);

    // Randomized traffic.
    clear_logs();
    rnd   = 1'b1;
    total = 0;
    for (int i = 0; i < 150; i++) begin
      t.sel = 2'($urandom_range(0, 3));
      t.len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      ctlq.push_back(t);
      for (int j = 0; j <= int'(t.len); j++) src[t.sel].push_back(N'($urandom));
      total += int'(t.len) + 1;
    end
    aop    = 100;
    budget = 20000;
    while (budget > 0 && (ctlq.size() != 0 || outq.size() != 0 || !m_idle ||
           src[0].size() != 0 || src[1].size() != 0 || src[2].size() != 0 || src[3].size() != 0)) begin
      if (cyc % 64 == 0) aop = (aop == 100) ? 55 : (aop == 55) ? 15 : 100;
      bus.a_o = ($urandom_range(0, 99) < aop);
      step();
      budget--;
    end
    check("rnd_total", 32'(popped.size()), 32'(total));
    check("rnd_drained", 32'(outq.size()), 32'd0);
    rnd = 1'b0;
    drive();

    // Three-channel instance: out-of-range token, then a valid single-item token.
    bus3.a_o     = 1'b1;
    bus3.ctl_sel = 2'd3;
    bus3.ctl_len = 4'd5;
    bus3.ctl_r   = 1'b1;
    @(negedge clk);
    check("bad_ctl_a_pre", 32'(bus3.ctl_a), 32'd1);
    @(posedge clk);
    #1;
    bus3.ctl_r = 1'b0;
    @(negedge clk);
    check("bad_err", 32'(bus3.err), 32'd1);
    check("bad_a_i", 32'(bus3.a_i), 32'd0);
    check("bad_ctl_a", 32'(bus3.ctl_a), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bad_err_clr", 32'(bus3.err), 32'd0);
    check("bad_a_i_2", 32'(bus3.a_i), 32'd0);
    @(posedge clk);
    #1;
    bus3.ctl_sel = 2'd0;
    bus3.ctl_len = 4'd0;
    bus3.ctl_r   = 1'b1;
    bus3.r_i     = 3'b001;
    bus3.d_i     = 24'h00005A;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      c = int'(bus3.ctl_r && bus3.ctl_a);
      if (bus3.r_i[0] && bus3.a_i[0]) got = 1;
      @(posedge clk);
      #1;
      if (c != 0) bus3.ctl_r = 1'b0;
      if (got != 0) bus3.r_i = '0;
    end
    check("bad_next_accept", 32'(got), 32'd1);
    @(negedge clk);
    check("bad_next_r_o", 32'(bus3.r_o), 32'd1);
    check("bad_next_d_o", 32'(bus3.d_o), 32'h5A);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bad_next_drain", 32'(bus3.r_o), 32'd0);
    check("bad_next_idle", 32'(bus3.ctl_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/muxn.md
# muxn

Clocked, N-channel conditional multiplexer with burst control. It is the synchronous, parametrised successor to the two-input handshake mux. A control token on the `ctl` channel selects one of `CH` input channels and a burst length. The block then forwards exactly that many items from the selected channel to a registered two-entry output buffer, and then returns for the next token. It sits between parallel producers and a single consumer anywhere a data-dependent merge with ordering guarantees is needed.

## Interface
- `N`, 8, data width per item
- `CH`, 4, number of input channels (≥2)
- `LW`, 4, burst-length field width; a burst carries `ctl_len+1` items (1..2^LW)
- `SW`, derived, `$clog2(CH)`, select field width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low (`rst=0` resets)
- `r_i`  in  CH  per-channel request (level, valid-style)
- `a_i`  out  CH  per-channel acknowledge (ready-style)
- `d_i`  in  CH*N  channel k data at `d_i[k*N +: N]`
- `ctl_r`  in  1  control token request
- `ctl_a`  out  1  control token acknowledge
- `ctl_sel`  in  SW  selected channel
- `ctl_len`  in  LW  burst length minus one
- `r_o`  out  1  output request
- `a_o`  in  1  output acknowledge
- `d_o`  out  N  output data
- `err`  out  1  one-cycle pulse: token with `ctl_sel ≥ CH` was discarded

## Operation
- A transfer on any channel occurs in a cycle where its `r` and `a` are both 1 at the rising edge. `r` must stay high and data must stay stable until that transfer.
- State machine states:
  - IDLE:
    - `ctl_a=1` (registered). All `a_i=0`.
    - On a ctl transfer with `ctl_sel<CH`: latch `sel←ctl_sel` and `rem←ctl_len`, then go to BURST.
    - On a ctl transfer with `ctl_sel≥CH`: consume the token, pulse `err` next cycle, stay in IDLE.
  - BURST:
    - `ctl_a=0`. `a_i[sel] = (cnt≠2)`. All other `a_i=0`.
    - On an input transfer: push `d_i[sel]` into the buffer.
    - If `rem==0`, go to IDLE. Otherwise `rem←rem−1`.
- Output buffer: 2-entry FIFO, `cnt` ∈ {0,1,2}.
  - `r_o=(cnt≠0)`. `d_o` = head entry, held stable while `r_o=1` and not acknowledged.
  - Pop on `r_o&&a_o`.
  - Push and pop in the same cycle: `cnt` unchanged, order preserved.
- `a_i[sel]` depends only on registered `cnt`. There is no combinational path from `a_o` to `a_i`.
- Items within a burst are never reordered or dropped. Bursts leave the block in token order.
- `ctl_len` is unsigned. Max burst 2^LW items; `rem` never wraps below 0.
- `ctl_sel`/`ctl_len` values while `ctl_a=0` are ignored.

## Timing
- Reset values (while `rst=0`, asynchronously):
  - state=IDLE, `cnt=0`, `rem=0`, `sel=0`
  - `r_o=0`, `d_o=0`, `a_i=0`, `err=0`
  - `ctl_a=0`
- `ctl_a` rises on the first clock edge after `rst` deasserts.
- Ctl accepted at edge t: `a_i[sel]` may be 1 from cycle t+1.
- Input accepted at edge t: item visible on `d_o` with `r_o=1` from t+1 (latency 1).
- Last item of a burst accepted at edge t: IDLE and `ctl_a=1` at t+1. The next token is accepted at t+1 at the earliest, and its first item at t+2. This gives one dead input cycle between bursts.
- Sustained throughput inside a burst is 1 item/cycle when `a_o` is held 1.
- With `a_o=0`, two items are accepted, then `a_i[sel]` drops at the cycle `cnt` reaches 2. It reasserts the cycle after the first pop.
- `err` is high for exactly the cycle after the bad-token edge. A bad token costs one cycle.
- Reset asserted mid-burst: the burst is abandoned, buffered items are discarded, and all outputs return to reset values immediately (asynchronously).

## Test plan
- Reset: hold `rst=0` with all inputs toggling → `r_o=0`, `a_i=0`, `ctl_a=0`, `d_o=0`; release → `ctl_a=1` one edge later.
- Single burst: token sel=2, len=3; channel 2 supplies 0x11,0x22,0x33,0x44, `a_o=1` → `d_o` shows them in order on consecutive cycles; `a_i[0,1,3]` stay 0; `ctl_a` returns to 1 after the 4th transfer.
- Backpressure: sel=1, len=5, `a_o=0` → exactly 2 items accepted, `a_i[1]` drops. Release `a_o` → all 6 items are delivered in order with none lost or duplicated.
- Bad token: CH=3, `ctl_sel=3` → `err` high for one cycle and no `a_i` asserted. The next valid token (sel=0, len=0) passes a single item.
- Back-to-back tokens: sel=0 len=0, then sel=3 len=1 → output order is ch0 item, then two ch3 items, with one idle input cycle between bursts.
- Reset mid-burst: assert `rst` after 2 of 8 items with `cnt=2` → `r_o=0` immediately. After release, a new token sel=1 len=0 delivers only the new channel-1 item.
